// File: rtl/audio_agc_limiter.sv
// audio_agc_limiter
//   Converts wide signed audio samples into a held, saturated, signed 8-bit sample
//   for the PWM stage. A power-of-two gain is applied in stage 1; stage 2 rescales,
//   saturates to +/-127 and registers the result. A windowed peak/clip AGC adjusts
//   the gain once per WIN_LEN output samples. The output is limited to +/-127 because
//   the PWM stage adds 127, and -128 would wrap to full-on.
module audio_agc_limiter #(
  parameter int IN_W      = 12,
  parameter int MAX_SHIFT = 7,
  parameter int INIT_GAIN = 0,
  parameter int WIN_LEN   = 256,
  parameter int CLIP_LIM  = 4,
  parameter int LOW_THR   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] din,
  input  logic                   din_valid,
  input  logic                   agc_en,
  input  logic [2:0]             manual_gain,
  output logic signed [7:0]      dout,
  output logic                   dout_valid,
  output logic                   clip,
  output logic [2:0]             gain
);

  localparam int SW    = IN_W + MAX_SHIFT;
  localparam int CNT_W = $clog2(WIN_LEN + 1);

  localparam logic signed [SW-1:0] POS_LIM = SW'(127);
  localparam logic signed [SW-1:0] NEG_LIM = -SW'(127);

  // Stage 1 state: gained sample and its valid flag.
  logic                 s1_valid;
  logic signed [SW-1:0] s1_s;

  // Stage 2 combinational result.
  logic signed [SW-1:0] t;
  logic signed [7:0]    sat_val;
  logic                 sat_clip;
  logic [7:0]           neg_val;
  logic [6:0]           mag;

  // AGC window state.
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] clip_cnt;
  logic [6:0]       peak;
  logic             win_close;

  logic signed [SW-1:0] din_ext;
  logic [2:0]           manual_clamped;

  assign din_ext        = {{MAX_SHIFT{din[IN_W-1]}}, din};
  assign manual_clamped = (int'(manual_gain) > MAX_SHIFT) ? 3'(MAX_SHIFT) : manual_gain;

  // Stage 1: capture the input scaled by the gain in force at this clk.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order; blocking here would create races.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= '0;
    end else begin
      s1_valid <= din_valid;
      if (din_valid) s1_s <= din_ext <<< gain;
    end
  end

  // Stage 2 datapath: floor rescale to 8 bits and symmetric saturation.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    t        = s1_s >>> (IN_W - 8);
    sat_val  = t[7:0];
    sat_clip = 1'b0;
    if (t > POS_LIM) begin
      sat_val  = 8'sd127;
      sat_clip = 1'b1;
    end else if (t < NEG_LIM) begin
      sat_val  = -8'sd127;
      sat_clip = 1'b1;
    end
    neg_val = 8'd0 - sat_val;
    mag     = sat_val[7] ? neg_val[6:0] : sat_val[6:0];
  end

  // Stage 2 register: held output sample with single-clk valid/clip pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      clip       <= 1'b0;
    end else begin
      dout_valid <= s1_valid;
      clip       <= s1_valid & sat_clip;
      if (s1_valid) dout <= sat_val;
    end
  end

  // Window accumulation; the clk after a close clears the window and any sample
  // arriving on that clk becomes the first sample of the new window.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt   <= '0;
      clip_cnt  <= '0;
      peak      <= '0;
      win_close <= 1'b0;
    end else begin
      win_close <= 1'b0;
      if (win_close) begin
        win_cnt  <= s1_valid ? CNT_W'(1) : '0;
        peak     <= s1_valid ? mag : '0;
        clip_cnt <= (s1_valid && sat_clip) ? CNT_W'(1) : '0;
      end else if (s1_valid) begin
        win_cnt <= win_cnt + CNT_W'(1);
        if (mag > peak) peak <= mag;
        if (sat_clip && (clip_cnt != '1)) clip_cnt <= clip_cnt + CNT_W'(1);
        if (win_cnt == CNT_W'(WIN_LEN - 1)) win_close <= 1'b1;
      end
    end
  end

  // Gain: follows the manual setting when AGC is off, otherwise steps once per window.
  always_ff @(posedge clk) begin
    if (rst) begin
      gain <= 3'(INIT_GAIN);
    end else if (!agc_en) begin
      gain <= manual_clamped;
    end else if (win_close) begin
      if ((int'(clip_cnt) >= CLIP_LIM) && (gain != 3'd0))
        gain <= gain - 3'd1;
      else if ((int'(peak) < LOW_THR) && (int'(gain) < MAX_SHIFT))
        gain <= gain + 3'd1;
    end
  end

endmodule

// File: tb/tb_audio_agc_limiter.sv
// Directed testbench for audio_agc_limiter with hand-computed expected values.
module tb_audio_agc_limiter;

  logic              clk;
  logic              rst;
  logic signed [11:0] din;
  logic              din_valid;
  logic              agc_en;
  logic [2:0]        manual_gain;
  logic signed [7:0] dout;
  logic              dout_valid;
  logic              clip;
  logic [2:0]        gain;

  int errors = 0;
  int checks = 0;

  // Expected gains per window boundary and mid-window dout values.
  int g3_exp[5] = '{0, 1, 2, 3, 3};
  int d3_exp[4] = '{-7, -13, -25, -50};
  int g4_exp[4] = '{3, 2, 1, 1};
  int d4_exp[3] = '{127, 127, 125};
  int c4_exp[3] = '{1, 1, 0};

  audio_agc_limiter dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .agc_en     (agc_en),
    .manual_gain(manual_gain),
    .dout       (dout),
    .dout_valid (dout_valid),
    .clip       (clip),
    .gain       (gain)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample: latency, value, clip, pulse width and hold.
  task automatic send_one(input string tag, input int val, input int exp_d, input int exp_c);
    din       = 12'(val);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check({tag, "_lat"}, int'(dout_valid), 0);
    tick();
    check({tag, "_vld"}, int'(dout_valid), 1);
    check({tag, "_dout"}, int'($signed(dout)), exp_d);
    check({tag, "_clip"}, int'(clip), exp_c);
    tick();
    check({tag, "_pulse"}, int'(dout_valid), 0);
    check({tag, "_hold"}, int'($signed(dout)), exp_d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    din         = '0;
    din_valid   = 1'b0;
    agc_en      = 1'b1;
    manual_gain = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_dout", int'($signed(dout)), 0);
    check("rst_vld", int'(dout_valid), 0);
    check("rst_clip", int'(clip), 0);
    check("rst_gain", int'(gain), 0);

    // 1: unity gain saturation behaviour.
    send_one("t1_pos", 2047, 127, 0);
    send_one("t1_neg", -2048, -127, 1);

    // 2: manual gain, floor rounding.
    agc_en      = 1'b0;
    manual_gain = 3'd2;
    tick();
    check("t2_gain", int'(gain), 2);
    send_one("t2_p100", 100, 25, 0);
    send_one("t2_m100", -100, -25, 0);
    manual_gain = 3'd7;
    tick();
    send_one("t2_m1_g7", -1, -8, 0);
    manual_gain = 3'd0;
    tick();
    send_one("t2_m1_g0", -1, -1, 0);

    // 3: quiet alternating +/-100 raises gain 0->1->2->3, then holds.
    do_reset();
    agc_en      = 1'b0;
    manual_gain = 3'd0;
    tick();
    agc_en = 1'b1;
    for (int i = 0; i < 1026; i++) begin
      din       = (i % 2 == 0) ? 12'sd100 : -12'sd100;
      din_valid = 1'b1;
      tick();
      if (i >= 256 && i % 256 == 0) check("t3_gain_old", int'(gain), g3_exp[i/256 - 1]);
      if (i >= 257 && i % 256 == 1) check("t3_gain_new", int'(gain), g3_exp[i/256]);
      if (i < 1024 && i % 256 == 20) check("t3_dout", int'($signed(dout)), d3_exp[i/256]);
    end
    din_valid = 1'b0;
    tick();
    tick();

    // 4: clipping lowers gain 3->2->1, then holds at 1.
    do_reset();
    agc_en      = 1'b0;
    manual_gain = 3'd3;
    tick();
    tick();
    check("t4_gain_start", int'(gain), 3);
    agc_en = 1'b1;
    for (int i = 0; i < 770; i++) begin
      din       = 12'sd1000;
      din_valid = 1'b1;
      tick();
      if (i >= 256 && i % 256 == 0) check("t4_gain_old", int'(gain), g4_exp[i/256 - 1]);
      if (i >= 257 && i % 256 == 1) check("t4_gain_new", int'(gain), g4_exp[i/256]);
      if (i < 768 && i % 256 == 20) begin
        check("t4_dout", int'($signed(dout)), d4_exp[i/256]);
        check("t4_clip", int'(clip), c4_exp[i/256]);
      end
    end
    din_valid = 1'b0;
    tick();
    tick();

    // 5: reset with two samples in flight drops both.
    agc_en      = 1'b0;
    manual_gain = 3'd5;
    tick();
    check("t5_pre_dout", int'($signed(dout)), 125);
    check("t5_pre_gain", int'(gain), 5);
    din       = 12'sd500;
    din_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    din_valid = 1'b0;
    check("t5_rst_dout", int'($signed(dout)), 0);
    check("t5_rst_vld", int'(dout_valid), 0);
    check("t5_rst_gain", int'(gain), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_vld", int'(dout_valid), 0);
      check("t5_dout0", int'($signed(dout)), 0);
    end

    // 6: sample arriving on the window-clear clk starts the new window.
    manual_gain = 3'd0;
    do_reset();
    tick();
    agc_en = 1'b1;
    for (int i = 0; i < 520; i++) begin
      din       = (i == 256) ? 12'sd2047 : 12'sd0;
      din_valid = 1'b1;
      tick();
      if (i == 256) check("t6_gain_old", int'(gain), 0);
      if (i == 257) begin
        check("t6_gain_up", int'(gain), 1);
        check("t6_loud_dout", int'($signed(dout)), 127);
        check("t6_loud_clip", int'(clip), 0);
      end
      if (i == 519) check("t6_gain_hold", int'(gain), 1);
    end
    din_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
